// File: rtl/vec_pcpi_decoder_if.sv
// vec_pcpi_decoder_if
// Bundles the PicoRV32 PCPI handshake and the vector-unit command bus that
// the vec_pcpi_decoder sits between.
//   slave  modport : decoder view (takes PCPI requests, drives the vector unit)
//   master modport : CPU / vector-unit view (drives requests, receives results)
// Signals:
//   pcpi_valid/insn/rs1 : instruction offered by the CPU
//   pcpi_wr/rd          : result write-back, meaningful while pcpi_ready is high
//   pcpi_wait           : decoder busy with the accepted instruction
//   pcpi_ready          : one-cycle completion pulse
//   vu_start            : one-cycle start pulse to the vector unit
//   vu_funct/vs1/vs2/vr : decoded command fields
//   vu_vl               : vector length sent with the command
//   vu_op_done          : completion pulse from the vector unit
interface vec_pcpi_decoder_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        vu_start;
  logic [6:0]  vu_funct;
  logic [4:0]  vu_vs1;
  logic [4:0]  vu_vs2;
  logic [4:0]  vu_vr;
  logic [24:0] vu_vl;
  logic        vu_op_done;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, vu_op_done,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
           vu_start, vu_funct, vu_vs1, vu_vs2, vu_vr, vu_vl
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, vu_op_done,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
           vu_start, vu_funct, vu_vs1, vu_vs2, vu_vr, vu_vl
  );
endinterface

// File: rtl/vec_pcpi_decoder.sv
// vec_pcpi_decoder
// Issue stage for the vector unit. Watches the PCPI port for custom-0
// instructions (funct3 = 0), turns vector commands into a one-cycle start
// pulse with latched command fields, holds the CPU with pcpi_wait until the
// unit reports done (or a timeout expires), then completes the handshake.
// VSETVL is handled locally: it updates the vector-length register and
// returns the new value to rd.
// Parameters:
//   VECTOR_LENGTH  : maximum elements per vector, VSETVL clamp value
//   TIMEOUT_CYCLES : cycles to wait for vu_op_done (2..255)
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   bus         : PCPI + vector-unit signals (slave modport)
//   vl_q        : architectural vector-length register
//   err_timeout : sticky, set whenever the unit failed to answer in time
module vec_pcpi_decoder #(
  parameter int VECTOR_LENGTH  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  vec_pcpi_decoder_if.slave  bus,
  output logic [31:0]        vl_q,
  output logic               err_timeout
);

  localparam logic [31:0] VL_MAX      = 32'(VECTOR_LENGTH);
  localparam logic [7:0]  CNT_LAST    = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0]  F7_VADD     = 7'b0000000;
  localparam logic [6:0]  F7_VSUB     = 7'b0000001;
  localparam logic [6:0]  F7_VMUL     = 7'b0000010;
  localparam logic [6:0]  F7_VLE      = 7'b1000000;
  localparam logic [6:0]  F7_VSE      = 7'b0100000;
  localparam logic [6:0]  F7_VSETVL   = 7'b0000111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        aborted;

  logic        start_q;
  logic        wait_q;
  logic        ready_q;
  logic        wr_q;
  logic [31:0] rd_q;
  logic [6:0]  funct_q;
  logic [4:0]  vs1_q;
  logic [4:0]  vs2_q;
  logic [4:0]  vr_q;
  logic [24:0] vl_out_q;

  logic [6:0]  funct7;
  logic        insn_match;
  logic        is_vec;
  logic        is_setvl;
  logic [31:0] vl_new;

  // Instruction decode and the clamped VSETVL value, evaluated every cycle
  // but only acted on while the FSM is idle.
  always_comb begin
    funct7     = bus.pcpi_insn[31:25];
    insn_match = (bus.pcpi_insn[6:0] == OPC_CUSTOM0) &&
                 (bus.pcpi_insn[14:12] == 3'b000);
    is_vec     = insn_match && ((funct7 == F7_VADD) || (funct7 == F7_VSUB) ||
                                (funct7 == F7_VMUL) || (funct7 == F7_VLE)  ||
                                (funct7 == F7_VSE));
    is_setvl   = insn_match && (funct7 == F7_VSETVL);
    vl_new     = (bus.pcpi_rs1 > VL_MAX) ? VL_MAX : bus.pcpi_rs1;
  end

  // Control FSM. All outputs are registered: each is computed on the edge
  // that enters the state in which it must be visible. Pulse outputs
  // default low so they last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      aborted     <= 1'b0;
      start_q     <= 1'b0;
      wait_q      <= 1'b0;
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      funct_q     <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vr_q        <= '0;
      vl_out_q    <= '0;
      vl_q        <= VL_MAX;
      err_timeout <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      case (state)
        S_IDLE: begin
          if (bus.pcpi_valid && is_vec) begin
            state    <= S_ISSUE;
            start_q  <= 1'b1;
            wait_q   <= 1'b1;
            aborted  <= 1'b0;
            funct_q  <= funct7;
            vs1_q    <= bus.pcpi_insn[19:15];
            vs2_q    <= bus.pcpi_insn[24:20];
            vr_q     <= bus.pcpi_insn[11:7];
            vl_out_q <= vl_q[24:0];
          end else if (bus.pcpi_valid && is_setvl) begin
            state   <= S_RESP;
            vl_q    <= vl_new;
            ready_q <= 1'b1;
            wr_q    <= 1'b1;
            rd_q    <= vl_new;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= '0;
          if (!bus.pcpi_valid) aborted <= 1'b1;
        end
        S_WAIT: begin
          // Done takes priority over an expiring timeout in the same cycle.
          // A CPU that dropped pcpi_valid while we waited gets no ready.
          if (bus.vu_op_done || (cnt == CNT_LAST)) begin
            state   <= S_RESP;
            wait_q  <= 1'b0;
            ready_q <= !(aborted || !bus.pcpi_valid);
            if (!bus.vu_op_done) err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
            if (!bus.pcpi_valid) aborted <= 1'b1;
          end
        end
        S_RESP: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          // One dead cycle so a pcpi_valid still high from the completed
          // instruction is not mistaken for a new one.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.vu_start   = start_q;
  assign bus.pcpi_wait  = wait_q;
  assign bus.pcpi_ready = ready_q;
  assign bus.pcpi_wr    = wr_q;
  assign bus.pcpi_rd    = rd_q;
  assign bus.vu_funct   = funct_q;
  assign bus.vu_vs1     = vs1_q;
  assign bus.vu_vs2     = vs2_q;
  assign bus.vu_vr      = vr_q;
  assign bus.vu_vl      = vl_out_q;

endmodule

// File: tb/tb_vec_pcpi_decoder.sv
// tb_vec_pcpi_decoder
// Scoreboard bench for vec_pcpi_decoder. The stimulus process issues
// instructions and pushes the expected vector-unit command and PCPI response
// (including the edge on which each must appear) into queues; a separate
// monitor pops and compares whenever vu_start or pcpi_ready is seen.
// A small vector-unit model returns vu_op_done a programmable delay after
// vu_start, or never.
module tb_vec_pcpi_decoder;
  localparam int VLEN = 4;
  localparam int TOUT = 8;

  typedef struct {
    int          edge_num;
    logic        wr;
    logic [31:0] rd;
  } resp_t;

  typedef struct {
    int          edge_num;
    logic [6:0]  funct;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vr;
    logic [24:0] vl;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] vl_q;
  logic        err_timeout;

  vec_pcpi_decoder_if bus();

  vec_pcpi_decoder #(
    .VECTOR_LENGTH (VLEN),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .vl_q       (vl_q),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_count = 0;
  int exp_starts = 0;
  int vu_delay = 1;
  int vu_count = -1;
  int late_req = 0;
  int late_ack = 0;
  logic [31:0] vl_model = 32'(VLEN);
  logic        exp_err = 1'b0;

  resp_t resp_q[$];
  cmd_t  cmd_q[$];
  resp_t mon_resp;
  cmd_t  mon_cmd;

  // Edge counter: at a falling edge cyc equals the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [4:0] vs2,
                                          input logic [4:0] vs1, input logic [2:0] f3,
                                          input logic [4:0] vr, input logic [6:0] opc);
    return {f7, vs2, vs1, f3, vr, opc};
  endfunction

  function automatic bit is_vec_op(input logic [6:0] f7);
    return (f7 == 7'b0000000) || (f7 == 7'b0000001) || (f7 == 7'b0000010) ||
           (f7 == 7'b1000000) || (f7 == 7'b0100000);
  endfunction

  // Vector-unit model: done a fixed number of cycles after start, or never
  // (vu_delay < 0); late_req asks for a stray done pulse.
  always @(negedge clk) begin
    bus.vu_op_done = 1'b0;
    if (!rst_n) vu_count = -1;
    else if (bus.vu_start) vu_count = vu_delay;
    else if (vu_count > 0) begin
      vu_count--;
      if (vu_count == 0) begin
        bus.vu_op_done = 1'b1;
        vu_count = -1;
      end
    end
    if (late_req != late_ack) begin
      late_ack = late_req;
      bus.vu_op_done = 1'b1;
    end
  end

  // Monitor: every start pulse and every ready pulse must match the head of
  // its queue, including the edge it was expected on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vu_start) begin
        start_count++;
        checkOutput("vu_start_expected", 32'(cmd_q.size() > 0), 32'd1);
        if (cmd_q.size() > 0) begin
          mon_cmd = cmd_q.pop_front();
          checkOutput("vu_start_cycle", cyc, mon_cmd.edge_num);
          checkOutput("vu_funct", 32'(bus.vu_funct), 32'(mon_cmd.funct));
          checkOutput("vu_vs1", 32'(bus.vu_vs1), 32'(mon_cmd.vs1));
          checkOutput("vu_vs2", 32'(bus.vu_vs2), 32'(mon_cmd.vs2));
          checkOutput("vu_vr", 32'(bus.vu_vr), 32'(mon_cmd.vr));
          checkOutput("vu_vl", 32'(bus.vu_vl), 32'(mon_cmd.vl));
        end
      end
      if (bus.pcpi_ready) begin
        checkOutput("ready_expected", 32'(resp_q.size() > 0), 32'd1);
        checkOutput("wait_low_at_ready", 32'(bus.pcpi_wait), 32'd0);
        if (resp_q.size() > 0) begin
          mon_resp = resp_q.pop_front();
          checkOutput("ready_cycle", cyc, mon_resp.edge_num);
          checkOutput("pcpi_wr", 32'(bus.pcpi_wr), 32'(mon_resp.wr));
          checkOutput("pcpi_rd", bus.pcpi_rd, mon_resp.rd);
        end
      end
    end
  end

  // Issue one instruction at a falling edge.
  // d: done delay in cycles after vu_start (<0 = never).
  // mode: 0 normal, 1 hold pcpi_valid through HOLD, 2 CPU abort,
  //       3 long illegal hold, 4 async reset while waiting.
  task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1,
                               input int d, input int mode);
    logic [6:0] f7;
    bit         legal;
    bit         is_set;
    bit         is_vec;
    bit         times_out;
    bit         wait_seen;
    int         n;
    int         waited;
    resp_t      r;
    cmd_t       c;
    f7        = insn[31:25];
    legal     = (insn[6:0] == 7'b0001011) && (insn[14:12] == 3'b000);
    is_set    = legal && (f7 == 7'b0000111);
    is_vec    = legal && is_vec_op(f7);
    times_out = (d < 0) || (d > TOUT);
    vu_delay  = d;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_valid = 1'b1;
    n = cyc + 1;
    if (is_set) begin
      vl_model   = (rs1 > 32'(VLEN)) ? 32'(VLEN) : rs1;
      r.edge_num = n;
      r.wr       = 1'b1;
      r.rd       = vl_model;
      resp_q.push_back(r);
    end else if (is_vec) begin
      c.edge_num = n;
      c.funct    = f7;
      c.vs1      = insn[19:15];
      c.vs2      = insn[24:20];
      c.vr       = insn[11:7];
      c.vl       = vl_model[24:0];
      cmd_q.push_back(c);
      exp_starts++;
      if (mode == 0 || mode == 1) begin
        r.edge_num = n + 1 + (times_out ? TOUT : d);
        r.wr       = 1'b0;
        r.rd       = 32'd0;
        resp_q.push_back(r);
      end
      if (times_out && mode != 4) exp_err = 1'b1;
    end

    if (!is_set && !is_vec) begin
      wait_seen = 1'b0;
      repeat ((mode == 3) ? 20 : 3) begin
        @(negedge clk);
        if (bus.pcpi_wait) wait_seen = 1'b1;
      end
      checkOutput("illegal_no_wait", 32'(wait_seen), 32'd0);
      bus.pcpi_valid = 1'b0;
      @(negedge clk);
    end else begin
      @(negedge clk);
      if (is_vec) checkOutput("wait_after_match", 32'(bus.pcpi_wait), 32'd1);
      if (mode == 2) begin
        bus.pcpi_valid = 1'b0;
        repeat (d + 6) @(negedge clk);
        checkOutput("abort_wait_clear", 32'(bus.pcpi_wait), 32'd0);
      end else if (mode == 4) begin
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pcpi_wait", 32'(bus.pcpi_wait), 32'd0);
        checkOutput("rst_pcpi_ready", 32'(bus.pcpi_ready), 32'd0);
        checkOutput("rst_vu_start", 32'(bus.vu_start), 32'd0);
        checkOutput("rst_pcpi_wr", 32'(bus.pcpi_wr), 32'd0);
        checkOutput("rst_pcpi_rd", bus.pcpi_rd, 32'd0);
        checkOutput("rst_vu_funct", 32'(bus.vu_funct), 32'd0);
        checkOutput("rst_vu_vs1", 32'(bus.vu_vs1), 32'd0);
        checkOutput("rst_vu_vl", 32'(bus.vu_vl), 32'd0);
        checkOutput("rst_vl_q", vl_q, 32'(VLEN));
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
        vl_model = 32'(VLEN);
        exp_err  = 1'b0;
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end else begin
        waited = 0;
        while (!bus.pcpi_ready && waited < TOUT + 6) begin
          @(negedge clk);
          waited++;
        end
        checkOutput("ready_seen", 32'(bus.pcpi_ready), 32'd1);
        if (mode == 1) repeat (2) @(negedge clk);
        bus.pcpi_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      checkOutput("vl_q", vl_q, vl_model);
      checkOutput("err_timeout", 32'(err_timeout), 32'(exp_err));
    end
  endtask

  logic [6:0] vec_ops [5] = '{7'b0000000, 7'b0000001, 7'b0000010, 7'b1000000, 7'b0100000};

  initial begin : stimulus
    int          kind;
    int          variant;
    logic [6:0]  f7;
    logic [31:0] rs1;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = 32'd0;
    bus.pcpi_rs1   = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pcpi_wait", 32'(bus.pcpi_wait), 32'd0);
    checkOutput("reset_pcpi_ready", 32'(bus.pcpi_ready), 32'd0);
    checkOutput("reset_vu_start", 32'(bus.vu_start), 32'd0);
    checkOutput("reset_pcpi_rd", bus.pcpi_rd, 32'd0);
    checkOutput("reset_vl_q", vl_q, 32'(VLEN));
    checkOutput("reset_err_timeout", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] VSETVL then VADD");
    applyStimulus(mk_insn(7'b0000111, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0001011), 32'd3, 1, 0);
    applyStimulus(mk_insn(7'b0000000, 5'd0, 5'd1, 3'b000, 5'd2, 7'b0001011), 32'd0, 4, 0);

    $display("[TB] VSETVL clamp");
    applyStimulus(mk_insn(7'b0000111, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0001011), 32'd100, 1, 0);
    applyStimulus(mk_insn(7'b0000111, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0001011), 32'd0, 1, 0);
    applyStimulus(mk_insn(7'b0000111, 5'd0, 5'd1, 3'b000, 5'd3, 7'b0001011), 32'hFFFF_FFFF, 1, 0);

    $display("[TB] illegal funct7 held");
    applyStimulus(mk_insn(7'b0000011, 5'd4, 5'd5, 3'b000, 5'd6, 7'b0001011), 32'd0, 1, 3);

    $display("[TB] done on last timeout cycle, minimum latency, abort");
    applyStimulus(mk_insn(7'b0000001, 5'd9, 5'd8, 3'b000, 5'd7, 7'b0001011), 32'd0, TOUT, 0);
    applyStimulus(mk_insn(7'b1000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0001011), 32'd0, 1, 0);
    applyStimulus(mk_insn(7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0001011), 32'd0, 3, 2);

    $display("[TB] random instructions");
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        applyStimulus(mk_insn(7'b0000111, 5'($urandom), 5'($urandom), 3'b000,
                              5'($urandom), 7'b0001011), rs1, 1, 0);
      end else if (kind <= 7) begin
        f7 = vec_ops[$urandom_range(0, 4)];
        applyStimulus(mk_insn(f7, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom),
                              7'b0001011), $urandom, $urandom_range(1, TOUT),
                      (kind == 7) ? 1 : 0);
      end else begin
        variant = $urandom_range(0, 2);
        f7 = 7'($urandom);
        if (variant == 0)
          applyStimulus(mk_insn(f7, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom),
                                7'b0110011), $urandom, 1, 0);
        else if (variant == 1)
          applyStimulus(mk_insn(7'b0000000, 5'($urandom), 5'($urandom),
                                3'($urandom_range(1, 7)), 5'($urandom), 7'b0001011),
                        $urandom, 1, 0);
        else begin
          if (is_vec_op(f7) || f7 == 7'b0000111) f7 = 7'b0000011;
          applyStimulus(mk_insn(f7, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom),
                                7'b0001011), $urandom, 1, 0);
        end
      end
    end

    $display("[TB] timeout, late done, recovery");
    applyStimulus(mk_insn(7'b0000010, 5'd4, 5'd5, 3'b000, 5'd6, 7'b0001011), 32'd0, -1, 0);
    late_req++;
    repeat (4) @(negedge clk);
    checkOutput("late_done_no_wait", 32'(bus.pcpi_wait), 32'd0);
    applyStimulus(mk_insn(7'b0000001, 5'd10, 5'd11, 3'b000, 5'd12, 7'b0001011), 32'd0, 2, 0);

    $display("[TB] pcpi_valid held through HOLD");
    applyStimulus(mk_insn(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd1, 7'b0001011), 32'd0, 2, 1);
    applyStimulus(mk_insn(7'b0000111, 5'd0, 5'd0, 3'b000, 5'd1, 7'b0001011), 32'd2, 1, 1);

    $display("[TB] async reset during wait");
    applyStimulus(mk_insn(7'b0000010, 5'd7, 5'd6, 3'b000, 5'd5, 7'b0001011), 32'd0, -1, 4);
    applyStimulus(mk_insn(7'b0000000, 5'd2, 5'd3, 3'b000, 5'd4, 7'b0001011), 32'd0, 3, 0);

    repeat (3) @(negedge clk);
    checkOutput("vu_start_count", start_count, exp_starts);
    checkOutput("resp_queue_drained", resp_q.size(), 32'd0);
    checkOutput("cmd_queue_drained", cmd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vec_pcpi_decoder.md
# vec_pcpi_decoder

Upstream issue stage for the vector processing unit. Watches the PicoRV32 PCPI port and decodes custom-0 vector instructions into the unit's command fields. Issues a one-cycle start pulse, holds the CPU with `pcpi_wait` until the unit reports done, then completes the PCPI handshake. Also owns the architectural vector-length register, set by a VSETVL instruction and forwarded as `vl` on every issued command.

## Interface
- `VECTOR_LENGTH`, 4, maximum elements per vector; clamp value for VSETVL.
- `TIMEOUT_CYCLES`, 64, cycles to wait for `vu_op_done` before force-completing; range 2..255.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pcpi_valid`  in  1  CPU presents a co-processor instruction.
- `pcpi_insn`  in  32  instruction word.
- `pcpi_rs1`  in  32  rs1 register value.
- `pcpi_wr`  out  1  write `pcpi_rd` to rd; valid with `pcpi_ready`.
- `pcpi_rd`  out  32  result value.
- `pcpi_wait`  out  1  decoder has accepted the instruction and is busy.
- `pcpi_ready`  out  1  one-cycle completion pulse.
- `vu_start`  out  1  one-cycle start pulse to the vector unit.
- `vu_funct`  out  7  vector opcode.
- `vu_vs1`, `vu_vs2`, `vu_vr`  out  5 each  register indices.
- `vu_vl`  out  25  current vector length.
- `vu_op_done`  in  1  completion pulse from the vector unit.
- `vl_q`  out  32  current vector-length register.
- `err_timeout`  out  1  sticky flag; set when any timeout has occurred.

## Operation
- **Match condition:** `pcpi_insn[6:0]==7'b0001011` and `funct3==3'b000`. Field sources:
  - `vu_vr` = insn[11:7]
  - `vu_vs1` = insn[19:15]
  - `vu_vs2` = insn[24:20]
  - `vu_funct` = insn[31:25]
- **Supported funct7 values:**
  - Vector commands: 0000000 VADD, 0000001 VSUB, 0000010 VMUL, 1000000 VLE, 0100000 VSE.
  - 0000111 VSETVL.
  - Any other funct7, or an opcode/funct3 mismatch, is ignored. No wait, no ready; the CPU traps the instruction as illegal.
- **VSETVL:** `vl_q <= min(pcpi_rs1, VECTOR_LENGTH)`. Returns the new value with `pcpi_wr=1` and `pcpi_rd=new vl_q`. Does not touch the vector unit.
- **Vector command path:**
  - Latch the fields; `vu_vl = vl_q[24:0]`.
  - Pulse `vu_start` and wait for `vu_op_done`.
  - Complete with `pcpi_wr=0` and `pcpi_rd=0`.
- **States:**
  - IDLE: on a match, go to ISSUE (vector command) or RESP (VSETVL).
  - ISSUE: `vu_start=1`, `pcpi_wait=1`, clear the timeout counter; go to WAIT.
  - WAIT: `pcpi_wait=1`; the counter increments each cycle. Leave on `vu_op_done` (→ RESP) or when the counter reaches `TIMEOUT_CYCLES-1` (→ RESP, set `err_timeout`).
  - RESP: `pcpi_ready=1` for one cycle, `pcpi_wait=0`; go to HOLD.
  - HOLD: ignore `pcpi_valid` for one cycle, so a still-high `pcpi_valid` cannot re-issue; go to IDLE.
- **CPU abort:** if `pcpi_valid` falls in ISSUE or WAIT, keep waiting for done or timeout. In RESP suppress `pcpi_ready` and `pcpi_wr`, then go to HOLD.
- **Late done:** a `vu_op_done` arriving in any state other than WAIT is ignored.
- **Same-cycle events:** if done and the timeout end condition coincide, done wins and `err_timeout` is not set.
- **Output registering:** command fields are registered and hold their value until the next issue.

## Timing
- **Reset values:** all outputs 0, `vl_q=VECTOR_LENGTH`, state IDLE, counter 0. An asynchronous reset mid-operation aborts immediately to these values; `err_timeout` clears only on reset.
- **Vector command** (match sampled at edge N):
  - N+1: `vu_start=1`, `pcpi_wait=1`.
  - Done seen at edge M: `pcpi_ready=1` at M+1; decoder back in IDLE at M+3.
  - Minimum latency, issue to ready, is 3 cycles (done at N+2).
- **VSETVL** (match at edge N): `pcpi_ready=1`, `pcpi_wr=1` at N+1; IDLE at N+3.
- **Timeout:** `pcpi_ready` asserts `TIMEOUT_CYCLES+2` cycles after the match edge when done never arrives.
- `pcpi_wait` is asserted within 1 cycle of a match, well inside the CPU's PCPI timeout.

## Test plan
- **VADD:** VSETVL rs1=3, then VADD vr=2, vs1=1, vs2=0; unit model returns done 4 cycles after start → `vl_q=3`, `pcpi_rd=3`, `vu_start` exactly one pulse, `vu_funct=0`, `vu_vl=3`, ready 1 cycle after done with `pcpi_wr=0`.
- **VSETVL clamp:** rs1=100 → `pcpi_rd=4`, `vl_q=4`; rs1=0 → `pcpi_rd=0`.
- **Illegal funct7:** funct7=0000011 held for 20 cycles → `pcpi_wait`, `pcpi_ready` and `vu_start` all stay 0.
- **Timeout:** done never returned, `TIMEOUT_CYCLES=8` → ready at match+10 with `pcpi_wr=0`, `err_timeout=1`. A late done pulse is then ignored, and the next VSUB completes normally.
- **Reset and hold-off:** `rst_n` low during WAIT → all outputs 0 at once and `vl_q=4`. Separately, `pcpi_valid` held high through HOLD → exactly one `vu_start` per instruction.
